// File: rtl/p_sgn_apply_pkg.sv
// p_sgn_apply_pkg: shared perceptron datapath configuration (dtype + precision).
// Rev 1.0
`default_nettype none

package p_sgn_apply_pkg;

  typedef enum logic [1:0] {
    BOOL = 2'd0,
    INT  = 2'd1,
    FXP  = 2'd2,
    FP   = 2'd3
  } dtype_e;

  typedef struct packed {
    dtype_e     dtype;
    logic [7:0] prec;
  } dconf_t;

endpackage

`define DEF_DCONF p_sgn_apply_pkg::dconf_t'{dtype: p_sgn_apply_pkg::INT, prec: 8'd8}

`default_nettype wire

// File: rtl/p_sgn_apply_if.sv
// p_sgn_apply_if: valid/ready input and output beat channels of p_sgn_apply.
// Rev 1.0
`default_nettype none

interface p_sgn_apply_if #(
  parameter int PREC = 8
);
  logic            in_valid;
  logic            in_ready;
  logic            in_sign;
  logic [PREC-1:0] in_mag;
  logic            out_valid;
  logic            out_ready;
  logic [PREC-1:0] out_data;
  logic            out_ovf;

  modport master (
    output in_valid, in_sign, in_mag, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_sign, in_mag, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/p_sgn_apply_conv.sv
// p_sgn_conv: combinational sign application with saturation in the CONF format.
// Rev 1.0
`default_nettype none

module p_sgn_conv
  import p_sgn_apply_pkg::*;
#(
  parameter dconf_t CONF = `DEF_DCONF,
  localparam int    PREC = int'(CONF.prec)
) (
  input  wire logic            in_sign,
  input  wire logic [PREC-1:0] in_mag,
  output logic      [PREC-1:0] data,
  output logic                 ovf
);

  localparam logic [PREC-1:0] c_MAX_POS = {1'b0, {(PREC-1){1'b1}}};
  localparam logic [PREC-1:0] c_MIN_NEG = {1'b1, {(PREC-1){1'b0}}};

  always_comb begin
    data = '0;
    ovf  = 1'b0;
    case (CONF.dtype)
      BOOL: data[0] = in_mag[0] ^ in_sign;
      INT, FXP: begin
        if (!in_sign) begin
          if (!in_mag[PREC-1]) begin
            data = in_mag;
          end else begin
            data = c_MAX_POS;
            ovf  = 1'b1;
          end
        // The most negative value is reachable without overflow.
        end else if (!in_mag[PREC-1] || in_mag == c_MIN_NEG) begin
          data = '0 - in_mag;
        end else begin
          data = c_MIN_NEG;
          ovf  = 1'b1;
        end
      end
      FP:      data = {in_sign ^ in_mag[PREC-1], in_mag[PREC-2:0]};
      default: data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/p_sgn_apply.sv
// p_sgn_apply: signs a magnitude, saturates, and buffers results in a 2-entry FIFO.
// Rev 1.0
`default_nettype none

module p_sgn_apply
  import p_sgn_apply_pkg::*;
#(
  parameter dconf_t CONF = `DEF_DCONF,
  localparam int    PREC = int'(CONF.prec)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  p_sgn_apply_if.slave     bus,
  input  wire logic        ovf_clr,
  output logic      [15:0] ovf_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } fifo_state_e;

  fifo_state_e     r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [PREC-1:0] r_head_data;
  logic            r_head_ovf;
  logic [PREC-1:0] r_tail_data;
  logic            r_tail_ovf;
  logic [15:0]     r_ovf_cnt;

  logic [PREC-1:0] w_conv_data;
  logic            w_conv_ovf;
  logic            w_push;
  logic            w_pop;

  p_sgn_conv #(.CONF(CONF)) u_conv (
    .in_sign (bus.in_sign),
    .in_mag  (bus.in_mag),
    .data    (w_conv_data),
    .ovf     (w_conv_ovf)
  );

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready;

  // Head is the presented output; tail only holds a second beat in S_TWO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_data <= '0;
      r_head_ovf  <= 1'b0;
      r_tail_data <= '0;
      r_tail_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head_data <= w_conv_data;
            r_head_ovf  <= w_conv_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_head_data <= w_conv_data;
            r_head_ovf  <= w_conv_ovf;
          end else if (w_push) begin
            r_tail_data <= w_conv_data;
            r_tail_ovf  <= w_conv_ovf;
            r_in_ready  <= 1'b0;
            r_state     <= S_TWO;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_ovf  <= r_tail_ovf;
            r_in_ready  <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_push && w_conv_ovf && r_ovf_cnt != 16'hFFFF) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_head_data;
  assign bus.out_ovf   = r_head_ovf;
  assign ovf_cnt       = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_p_sgn_apply.sv
// tb_p_sgn_apply: directed vectors with a scoreboard queue checked by a monitor.
// Rev 1.0
`default_nettype none

module tb_p_sgn_apply;
  import p_sgn_apply_pkg::*;

  localparam dconf_t c_FP   = '{dtype: FP,   prec: 8'd8};
  localparam dconf_t c_BOOL = '{dtype: BOOL, prec: 8'd8};

  logic        clk = 1'b0;
  logic        reset;
  logic        ovf_clr;
  logic        aux_clr;
  logic [15:0] ovf_cnt;
  logic [15:0] fp_cnt;
  logic [15:0] bl_cnt;

  always #5 clk = ~clk;

  p_sgn_apply_if #(.PREC(8)) bus ();
  p_sgn_apply_if #(.PREC(8)) fp_bus ();
  p_sgn_apply_if #(.PREC(8)) bl_bus ();

  p_sgn_apply #(.CONF(`DEF_DCONF)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );
  p_sgn_apply #(.CONF(c_FP)) dut_fp (
    .clk(clk), .reset(reset), .bus(fp_bus), .ovf_clr(aux_clr), .ovf_cnt(fp_cnt)
  );
  p_sgn_apply #(.CONF(c_BOOL)) dut_bl (
    .clk(clk), .reset(reset), .bus(bl_bus), .ovf_clr(aux_clr), .ovf_cnt(bl_cnt)
  );

  typedef struct {
    logic [7:0] d;
    logic       o;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transfer happens at the next posedge; outputs are stable until then.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h/%b want none", bus.out_data, bus.out_ovf);
      end else begin
        e = sb_q.pop_front();
        chk("beat_data", {8'h00, bus.out_data}, {8'h00, e.d});
        chk("beat_ovf", {15'h0, bus.out_ovf}, {15'h0, e.o});
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] m, input logic [7:0] ed, input logic eo);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_mag   = m;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for mag %h", m);
      bus.in_valid = 1'b0;
    end else begin
      sb_q.push_back('{ed, eo});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("drain_queue", 16'(sb_q.size()), 16'd0);
  endtask

  initial begin
    reset         = 1'b1;
    ovf_clr       = 1'b0;
    aux_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_mag    = 8'h00;
    bus.out_ready = 1'b1;
    fp_bus.in_valid  = 1'b0; fp_bus.in_sign = 1'b0; fp_bus.in_mag = 8'h00; fp_bus.out_ready = 1'b1;
    bl_bus.in_valid  = 1'b0; bl_bus.in_sign = 1'b0; bl_bus.in_mag = 8'h00; bl_bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {15'h0, bus.out_valid}, 16'd0);
    chk("rst_in_ready", {15'h0, bus.in_ready}, 16'd1);
    chk("rst_out_data", {8'h00, bus.out_data}, 16'h0000);
    chk("rst_out_ovf", {15'h0, bus.out_ovf}, 16'd0);
    chk("rst_ovf_cnt", ovf_cnt, 16'h0000);

    // First beat driven as reset releases; accepted on the next edge.
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_mag   = 8'h05;
    chk("first_in_ready", {15'h0, bus.in_ready}, 16'd1);
    sb_q.push_back('{8'hFB, 1'b0});
    fp_bus.in_valid = 1'b1; fp_bus.in_sign = 1'b1; fp_bus.in_mag = 8'hC0;
    bl_bus.in_valid = 1'b1; bl_bus.in_sign = 1'b1; bl_bus.in_mag = 8'h01;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    fp_bus.in_valid = 1'b0;
    bl_bus.in_valid = 1'b0;
    chk("latency_out_valid", {15'h0, bus.out_valid}, 16'd1);
    chk("fp_valid", {15'h0, fp_bus.out_valid}, 16'd1);
    chk("fp_data", {8'h00, fp_bus.out_data}, 16'h0040);
    chk("fp_ovf", {15'h0, fp_bus.out_ovf}, 16'd0);
    chk("bool_valid", {15'h0, bl_bus.out_valid}, 16'd1);
    chk("bool_data", {8'h00, bl_bus.out_data}, 16'h0000);
    chk("bool_ovf", {15'h0, bl_bus.out_ovf}, 16'd0);

    send(1'b1, 8'h80, 8'h80, 1'b0);
    send(1'b1, 8'h81, 8'h80, 1'b1);
    send(1'b0, 8'h80, 8'h7F, 1'b1);
    send(1'b1, 8'h00, 8'h00, 1'b0);
    idle();
    chk("ovf_cnt_boundary", ovf_cnt, 16'd2);
    drain();

    // Backpressure: third beat must wait for space.
    bus.out_ready = 1'b0;
    send(1'b0, 8'h11, 8'h11, 1'b0);
    send(1'b1, 8'h22, 8'hDE, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_mag   = 8'h33;
    chk("full_in_ready", {15'h0, bus.in_ready}, 16'd0);
    chk("full_hold_data", {8'h00, bus.out_data}, 16'h0011);
    bus.out_ready = 1'b1;
    send(1'b0, 8'h33, 8'h33, 1'b0);
    idle();
    drain();

    // Streaming in state ONE: one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] m;
      logic       s;
      m = 8'(i * 7);
      s = i[0];
      send(s, m, s ? 8'(8'h00 - m) : m, 1'b0);
      if (i > 0) begin
        chk("stream_in_ready", {15'h0, bus.in_ready}, 16'd1);
        chk("stream_out_valid", {15'h0, bus.out_valid}, 16'd1);
      end
    end
    idle();
    drain();

    for (int i = 0; i < 65536; i++) send(1'b0, 8'hFF, 8'h7F, 1'b1);
    idle();
    chk("ovf_cnt_sat", ovf_cnt, 16'hFFFF);
    drain();

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_mag   = 8'hC0;
    ovf_clr      = 1'b1;
    chk("clr_in_ready", {15'h0, bus.in_ready}, 16'd1);
    sb_q.push_back('{8'h80, 1'b1});
    @(negedge clk);
    bus.in_valid = 1'b0;
    ovf_clr      = 1'b0;
    chk("ovf_cnt_clr", ovf_cnt, 16'h0000);
    send(1'b0, 8'h90, 8'h7F, 1'b1);
    idle();
    chk("ovf_cnt_after_clr", ovf_cnt, 16'd1);
    drain();

    // Reset with two beats buffered discards them.
    bus.out_ready = 1'b0;
    send(1'b0, 8'h01, 8'h01, 1'b0);
    send(1'b0, 8'h02, 8'h02, 1'b0);
    idle();
    chk("two_in_ready", {15'h0, bus.in_ready}, 16'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {15'h0, bus.out_valid}, 16'd0);
    chk("midrst_in_ready", {15'h0, bus.in_ready}, 16'd1);
    chk("midrst_ovf_cnt", ovf_cnt, 16'h0000);
    sb_q.delete();
    @(negedge clk);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b1, 8'h03, 8'hFD, 1'b0);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
